// File: rtl/key_demux_1to2_pkg.sv
// Shared definitions for the key-driven 1-to-2 demux: debounce FSM encoding
// and the default debounce length for a 50 MHz clk.
package key_demux_1to2_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } key_fsm_e;

  // 20 ms of stable level at 50 MHz
  localparam int DEBOUNCE_CYCLES_50MHZ = 1_000_000;

endpackage

// File: rtl/key_demux_1to2_filter.sv
// Key synchronizer plus debounce FSM; produces a clean level and a one-cycle
// pulse per accepted press (key is active-low).
//
// state       | meaning
// IDLE        | key released and stable
// FILTER_DOWN | fall seen, waiting for the low level to hold
// DOWN        | key pressed and stable
// FILTER_UP   | rise seen, waiting for the high level to hold
module key_filter
  import key_demux_1to2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_flag
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, prev;
  logic          fall, rise;
  logic [CW-1:0] cnt;
  key_fsm_e      state;

  assign fall = prev & ~sync2;
  assign rise = ~prev & sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // The terminal count is tested before the bounce edge so it wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_state <= 1'b1;
      key_flag  <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= FILTER_DOWN;
        end
        FILTER_DOWN: begin
          if (cnt == CNT_TC) begin
            state     <= DOWN;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b0;
          end else if (rise) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DOWN: begin
          cnt <= '0;
          if (rise) state <= FILTER_UP;
        end
        FILTER_UP: begin
          if (cnt == CNT_TC) begin
            state     <= IDLE;
            cnt       <= '0;
            key_state <= 1'b1;
          end else if (fall) begin
            state <= DOWN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_demux_1to2.sv
// Debounced push-button toggles a route register that steers one data bit,
// registered, to one of two LED outputs.
module key_demux_1to2
  import key_demux_1to2_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter logic IDLE_LVL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic din,
  output logic led_out_a,
  output logic led_out_b,
  output logic sel,
  output logic key_state,
  output logic key_flag
);

  key_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_filter (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_state(key_state),
    .key_flag (key_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel <= 1'b0;
    else if (key_flag) sel <= ~sel;
  end

  // Outputs use the registered sel, so a route change lands one edge after sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out_a <= IDLE_LVL;
      led_out_b <= IDLE_LVL;
    end else begin
      led_out_a <= sel ? IDLE_LVL : din;
      led_out_b <= sel ? din : IDLE_LVL;
    end
  end

endmodule
